// File: rtl/plab4_net_router_input_terminal_ctrl_tdm.sv
// Terminal-input controller for a ring router with a TDM domain schedule (timing-channel protection).
// Optional stall statistics: define PLAB4_NET_TDM_STATS_EN to add the stall_cnt port and counter.
module plab4_net_router_input_terminal_ctrl_tdm #(
    parameter int unsigned p_router_id      = 0,
    parameter int unsigned p_num_routers    = 8,
    parameter int unsigned p_num_free_nbits = 2,
    parameter int unsigned p_num_domains    = 2,
    parameter int unsigned p_slot_cycles    = 8,
    parameter int unsigned p_dead_cycles    = 2,
    parameter int unsigned c_dest_nbits     = $clog2(p_num_routers),
    parameter int unsigned c_dom_nbits      = ($clog2(p_num_domains) < 1) ? 1 : $clog2(p_num_domains)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [c_dest_nbits-1:0]     dest,
    input  logic [c_dom_nbits-1:0]      in_dom,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_num_free_nbits-1:0] num_free_west,
    input  logic [p_num_free_nbits-1:0] num_free_east,
    output logic [2:0]                  reqs,
    input  logic [2:0]                  grants,
    output logic [c_dom_nbits-1:0]      cur_dom,
    output logic                        slot_active
`ifdef PLAB4_NET_TDM_STATS_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int unsigned c_cnt_max   = (p_slot_cycles > p_dead_cycles) ? p_slot_cycles : p_dead_cycles;
    localparam int unsigned c_cnt_nbits = ($clog2(c_cnt_max) < 1) ? 1 : $clog2(c_cnt_max);
    localparam int unsigned c_fwd_nbits = c_dest_nbits + 1;

    localparam logic [c_cnt_nbits-1:0] c_slot_last = c_cnt_nbits'(p_slot_cycles - 1);
    localparam logic [c_cnt_nbits-1:0] c_dead_last =
        (p_dead_cycles == 0) ? '0 : c_cnt_nbits'(p_dead_cycles - 1);
    localparam logic [c_dom_nbits-1:0] c_dom_last  = c_dom_nbits'(p_num_domains - 1);

    localparam logic [c_dest_nbits-1:0]     c_id_dest = c_dest_nbits'(p_router_id);
    localparam logic [c_fwd_nbits-1:0]      c_id      = c_fwd_nbits'(p_router_id);
    localparam logic [c_fwd_nbits-1:0]      c_nrouter = c_fwd_nbits'(p_num_routers);
    localparam logic [c_fwd_nbits-1:0]      c_half    = c_fwd_nbits'(p_num_routers / 2);
    localparam logic [p_num_free_nbits-1:0] c_one     = p_num_free_nbits'(1);

    typedef enum logic {ACTIVE, DEAD} state_t;

    state_t                  state;
    logic [c_cnt_nbits-1:0]  cnt;
    logic [c_dom_nbits-1:0]  next_dom;
    logic [c_fwd_nbits-1:0]  dest_x;
    logic [c_fwd_nbits-1:0]  fwd;

    assign next_dom = (cur_dom == c_dom_last) ? '0 : cur_dom + c_dom_nbits'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ACTIVE;
            cnt         <= '0;
            cur_dom     <= '0;
            slot_active <= 1'b1;
        end else begin
            case (state)
                ACTIVE: begin
                    if (cnt == c_slot_last) begin
                        cnt <= '0;
                        // With no dead time the slot hands over directly to the next domain.
                        if (p_dead_cycles == 0) begin
                            cur_dom <= next_dom;
                        end else begin
                            state       <= DEAD;
                            slot_active <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + c_cnt_nbits'(1);
                    end
                end
                DEAD: begin
                    if (cnt == c_dead_last) begin
                        cnt         <= '0;
                        state       <= ACTIVE;
                        slot_active <= 1'b1;
                        cur_dom     <= next_dom;
                    end else begin
                        cnt <= cnt + c_cnt_nbits'(1);
                    end
                end
                default: begin
                    state       <= ACTIVE;
                    cnt         <= '0;
                    slot_active <= 1'b1;
                end
            endcase
        end
    end

    // Greedy route: forward distance modulo the ring size, ties go to NEXT.
    always_comb begin
        dest_x = {1'b0, dest};
        fwd    = (dest_x >= c_id) ? (dest_x - c_id) : (dest_x + c_nrouter - c_id);
        reqs   = '0;
        if (reset_n && in_val && slot_active && (in_dom == cur_dom)) begin
            if (dest == c_id_dest) begin
                reqs = 3'b010;
            end else if (fwd <= c_half) begin
                if (num_free_west > c_one) reqs = 3'b100;
            end else begin
                if (num_free_east > c_one) reqs = 3'b001;
            end
        end
    end

    assign in_rdy = |(reqs & grants);

`ifdef PLAB4_NET_TDM_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (in_val && !in_rdy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
